// File: rtl/fft_128_pkg.sv
// Shared definitions for the 128-point in-place FFT engine.
// Holds the transform dimensions, RAM word layout, FSM state encoding,
// butterfly address/twiddle helpers, the quarter-wave sine table and
// the halve-and-saturate helper used by the butterfly datapath.
package fft_128_pkg;

    localparam int N          = 128;
    localparam int LOG2N      = 7;
    localparam int DW         = 13;
    localparam int WORD_W     = 2 * DW;
    localparam int RE_LSB     = 0;
    localparam int IM_LSB     = DW;
    localparam int FRAC       = 12;
    localparam int SAMPLE_MAX = 4095;
    localparam int SAMPLE_MIN = -4096;

    typedef logic [LOG2N-1:0]       addr_t;
    typedef logic [LOG2N-2:0]       bfly_t;
    typedef logic [2:0]             stage_t;
    typedef logic [WORD_W-1:0]      word_t;
    typedef logic signed [DW-1:0]   sample_t;
    typedef logic signed [DW:0]     half_t;
    typedef logic signed [DW+1:0]   sum_t;
    typedef logic signed [2*DW:0]   prod_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WT,
        S_CALC,
        S_WR
    } state_t;

    localparam stage_t LAST_STAGE = stage_t'(LOG2N - 1);
    localparam bfly_t  LAST_BFLY  = bfly_t'(N / 2 - 1);

    // Top address of a butterfly: the bits of j above the span are moved
    // up by one to leave room for the top/bottom selector bit.
    function automatic addr_t top_addr(input stage_t stage, input bfly_t bfly);
        addr_t j;
        addr_t mask;
        j    = {1'b0, bfly};
        mask = (addr_t'(1) << stage) - addr_t'(1);
        return ((j & ~mask) << 1) | (j & mask);
    endfunction

    function automatic addr_t bot_addr(input stage_t stage, input bfly_t bfly);
        return top_addr(stage, bfly) | (addr_t'(1) << stage);
    endfunction

    // Twiddle index k = (j mod 2^s) << (6-s); at stage 6 the mask wraps to all ones.
    function automatic bfly_t twiddle_index(input stage_t stage, input bfly_t bfly);
        bfly_t mask;
        mask = (bfly_t'(1) << stage) - bfly_t'(1);
        return (bfly & mask) << (LAST_STAGE - stage);
    endfunction

    // round(4096 * sin(pi*i/64)) for i = 0..32; entry 32 is exactly 4096.
    function automatic logic [DW-1:0] quarter_sin(input logic [5:0] i);
        case (i)
            6'd0:  return 13'd0;
            6'd1:  return 13'd201;
            6'd2:  return 13'd401;
            6'd3:  return 13'd601;
            6'd4:  return 13'd799;
            6'd5:  return 13'd995;
            6'd6:  return 13'd1189;
            6'd7:  return 13'd1380;
            6'd8:  return 13'd1567;
            6'd9:  return 13'd1751;
            6'd10: return 13'd1931;
            6'd11: return 13'd2106;
            6'd12: return 13'd2276;
            6'd13: return 13'd2440;
            6'd14: return 13'd2598;
            6'd15: return 13'd2751;
            6'd16: return 13'd2896;
            6'd17: return 13'd3035;
            6'd18: return 13'd3166;
            6'd19: return 13'd3290;
            6'd20: return 13'd3406;
            6'd21: return 13'd3513;
            6'd22: return 13'd3612;
            6'd23: return 13'd3703;
            6'd24: return 13'd3784;
            6'd25: return 13'd3857;
            6'd26: return 13'd3920;
            6'd27: return 13'd3973;
            6'd28: return 13'd4017;
            6'd29: return 13'd4052;
            6'd30: return 13'd4076;
            6'd31: return 13'd4091;
            6'd32: return 13'd4096;
            default: return 13'd0;
        endcase
    endfunction

    // Halve a 15-bit butterfly sum (truncating) and clamp into Q1.12.
    function automatic sample_t half_sat(input sum_t s);
        half_t h;
        h = half_t'(s >>> 1);
        if (h > half_t'(SAMPLE_MAX)) begin
            return sample_t'(SAMPLE_MAX);
        end else if (h < half_t'(SAMPLE_MIN)) begin
            return sample_t'(SAMPLE_MIN);
        end else begin
            return sample_t'(h);
        end
    endfunction

endpackage

// File: rtl/fft_128_twiddle_rom.sv
// Combinational twiddle ROM for the 128-point FFT.
// Ports: idx (6-bit twiddle index k), cos_w = cos(2*pi*k/128) and
// nsin_w = -sin(2*pi*k/128), both signed Q1.12. Built from a
// quarter-wave table; +1.0 is clipped to 0x0FFF, -1.0 is exact (0x1000).
module fft_128_twiddle_rom
    import fft_128_pkg::*;
(
    input  logic [5:0] idx,
    output sample_t    cos_w,
    output sample_t    nsin_w
);

    logic [DW-1:0] cos_mag;
    logic [DW-1:0] sin_mag;

    // First quadrant plus k=32 use the table directly; k>32 mirrors
    // around pi/2, where cosine turns negative.
    always_comb begin
        cos_mag = '0;
        sin_mag = '0;
        cos_w   = '0;
        nsin_w  = '0;
        if (idx <= 6'd32) begin
            cos_mag = quarter_sin(6'd32 - idx);
            sin_mag = quarter_sin(idx);
            cos_w   = (cos_mag == 13'd4096) ? sample_t'(SAMPLE_MAX) : sample_t'(cos_mag);
            nsin_w  = sample_t'(13'd0 - sin_mag);
        end else begin
            cos_mag = quarter_sin(idx - 6'd32);
            sin_mag = quarter_sin(6'd0 - idx);
            cos_w   = sample_t'(13'd0 - cos_mag);
            nsin_w  = sample_t'(13'd0 - sin_mag);
        end
    end

endmodule

// File: rtl/fft_128.sv
// 128-point radix-2 DIT forward FFT, in place on an external dual-port RAM.
// Ports: clk, rst (async active-low), start (one-cycle request), busy,
// ram_we_a/b, ram_addr_a/b, ram_din_a/b (outputs to the RAM),
// ram_dout_a/b (RAM read data, one-cycle latency). Words are
// {imag, real} Q1.12; input is bit-reversed, output natural order,
// each stage scaled by 1/2. Each butterfly takes RD, WT, CALC, WR.
module fft_128
    import fft_128_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        ram_we_a,
    output logic        ram_we_b,
    output addr_t       ram_addr_a,
    output addr_t       ram_addr_b,
    output word_t       ram_din_a,
    output word_t       ram_din_b,
    input  word_t       ram_dout_a,
    input  word_t       ram_dout_b
);

    state_t  state;
    stage_t  stage;
    bfly_t   bfly;
    sample_t a_re, a_im, b_re, b_im;
    sample_t tw_re, tw_im;
    prod_t   prod_re, prod_im;
    sum_t    t_re, t_im;
    sample_t ap_re, ap_im, bp_re, bp_im;

    fft_128_twiddle_rom u_rom (
        .idx    (twiddle_index(stage, bfly)),
        .cos_w  (tw_re),
        .nsin_w (tw_im)
    );

    // Butterfly arithmetic on the registered operands; result is captured
    // into the write-data registers on the CALC -> WR edge.
    always_comb begin
        prod_re = prod_t'(b_re) * prod_t'(tw_re) - prod_t'(b_im) * prod_t'(tw_im);
        prod_im = prod_t'(b_re) * prod_t'(tw_im) + prod_t'(b_im) * prod_t'(tw_re);
        t_re    = sum_t'(prod_re >>> FRAC);
        t_im    = sum_t'(prod_im >>> FRAC);
        ap_re   = half_sat(sum_t'(a_re) + t_re);
        ap_im   = half_sat(sum_t'(a_im) + t_im);
        bp_re   = half_sat(sum_t'(a_re) - t_re);
        bp_im   = half_sat(sum_t'(a_im) - t_im);
    end

    // Sequencer: addresses are loaded on entry to RD and held for the whole
    // butterfly, so WR writes back to the same pair it read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            stage      <= '0;
            bfly       <= '0;
            ram_we_a   <= 1'b0;
            ram_we_b   <= 1'b0;
            ram_addr_a <= '0;
            ram_addr_b <= '0;
            ram_din_a  <= '0;
            ram_din_b  <= '0;
            a_re       <= '0;
            a_im       <= '0;
            b_re       <= '0;
            b_im       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_RD;
                        busy       <= 1'b1;
                        stage      <= '0;
                        bfly       <= '0;
                        ram_addr_a <= top_addr('0, '0);
                        ram_addr_b <= bot_addr('0, '0);
                    end
                end
                S_RD: begin
                    state <= S_WT;
                end
                S_WT: begin
                    state <= S_CALC;
                    a_re  <= ram_dout_a[RE_LSB +: DW];
                    a_im  <= ram_dout_a[IM_LSB +: DW];
                    b_re  <= ram_dout_b[RE_LSB +: DW];
                    b_im  <= ram_dout_b[IM_LSB +: DW];
                end
                S_CALC: begin
                    state     <= S_WR;
                    ram_we_a  <= 1'b1;
                    ram_we_b  <= 1'b1;
                    ram_din_a <= {ap_im, ap_re};
                    ram_din_b <= {bp_im, bp_re};
                end
                S_WR: begin
                    ram_we_a <= 1'b0;
                    ram_we_b <= 1'b0;
                    if (bfly == LAST_BFLY && stage == LAST_STAGE) begin
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        stage      <= '0;
                        bfly       <= '0;
                        ram_addr_a <= '0;
                        ram_addr_b <= '0;
                        ram_din_a  <= '0;
                        ram_din_b  <= '0;
                    end else if (bfly == LAST_BFLY) begin
                        state      <= S_RD;
                        stage      <= stage + 3'd1;
                        bfly       <= '0;
                        ram_addr_a <= top_addr(stage + 3'd1, '0);
                        ram_addr_b <= bot_addr(stage + 3'd1, '0);
                    end else begin
                        state      <= S_RD;
                        bfly       <= bfly + 6'd1;
                        ram_addr_a <= top_addr(stage, bfly + 6'd1);
                        ram_addr_b <= bot_addr(stage, bfly + 6'd1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_128.sv
// Self-checking bench for fft_128 with a behavioural dual-port RAM.
// Expected spectra come from a direct floating-point DFT of each input
// and are queued when the input is loaded, then popped and compared
// against RAM contents once busy falls.
module tb_fft_128;
    import fft_128_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  start;
    logic  busy;
    logic  ram_we_a, ram_we_b;
    addr_t ram_addr_a, ram_addr_b;
    word_t ram_din_a, ram_din_b;
    word_t ram_dout_a, ram_dout_b;

    logic  load_en;
    addr_t load_addr;
    word_t load_data;
    word_t mem [0:N-1];

    typedef struct {
        int re;
        int im;
    } bin_t;

    bin_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    fft_128 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .ram_we_a   (ram_we_a),
        .ram_we_b   (ram_we_b),
        .ram_addr_a (ram_addr_a),
        .ram_addr_b (ram_addr_b),
        .ram_din_a  (ram_din_a),
        .ram_din_b  (ram_din_b),
        .ram_dout_a (ram_dout_a),
        .ram_dout_b (ram_dout_b)
    );

    always #5 clk = ~clk;

    // Dual-port RAM with one-cycle read latency; the bench load port
    // takes priority and is used only while the engine is idle.
    always @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else begin
            if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
            if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
        end
        ram_dout_a <= mem[ram_addr_a];
        ram_dout_b <= mem[ram_addr_b];
    end

    task automatic checkOutput(input string tag, input int observed, input int expected, input int tol);
        int diff;
        checks++;
        diff = observed - expected;
        if (diff > tol || diff < -tol) begin
            failures++;
            $display("[TB] FAIL %s observed=%0d expected=%0d tol=%0d", tag, observed, expected, tol);
        end
    endtask

    function automatic addr_t bitrev7(input addr_t v);
        addr_t r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // Builds one input pattern, loads it bit-reversed and queues X[k]/128.
    task automatic applyStimulus(input int pattern);
        int  xr [N];
        int  xi [N];
        real pi_c = 3.141592653589793;
        real sr, si, ang;
        logic [DW-1:0] fr, fi;
        bin_t e;
        for (int n = 0; n < N; n++) begin
            case (pattern)
                0: begin xr[n] = 4095; xi[n] = 0; end
                1: begin xr[n] = ((n & 2) != 0) ? 4095 : -4096; xi[n] = 0; end
                2: begin xr[n] = (n < 64) ? 4095 : -4096; xi[n] = 0; end
                default: begin
                    xr[n] = int'($urandom_range(0, 4000)) - 2000;
                    xi[n] = int'($urandom_range(0, 4000)) - 2000;
                end
            endcase
        end
        for (int n = 0; n < N; n++) begin
            fr        = xr[n][DW-1:0];
            fi        = xi[n][DW-1:0];
            load_en   = 1'b1;
            load_addr = bitrev7(addr_t'(n));
            load_data = {fi, fr};
            @(posedge clk); #1;
        end
        load_en = 1'b0;
        for (int k = 0; k < N; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int n = 0; n < N; n++) begin
                ang = 2.0 * pi_c * real'((k * n) % N) / real'(N);
                sr += real'(xr[n]) * $cos(ang) + real'(xi[n]) * $sin(ang);
                si += real'(xi[n]) * $cos(ang) - real'(xr[n]) * $sin(ang);
            end
            e.re = int'(sr / real'(N));
            e.im = int'(si / real'(N));
            sb.push_back(e);
        end
    endtask

    // Pulses start and follows the run; optionally re-pulses start or
    // drops reset at a given busy cycle.
    task automatic run_transform(input int repulse_at, input int reset_at, output bit aborted);
        int cyc = 0;
        int wa  = 0;
        int wb  = 0;
        aborted = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_rise", int'(busy), 1, 0);
        while (busy && cyc < 4000) begin
            cyc++;
            if (ram_we_a) wa++;
            if (ram_we_b) wb++;
            start = (cyc == repulse_at);
            if (cyc == reset_at) begin
                #2;
                rst = 1'b0;
                #1;
                checkOutput("rst_busy", int'(busy), 0, 0);
                checkOutput("rst_we_a", int'(ram_we_a), 0, 0);
                checkOutput("rst_we_b", int'(ram_we_b), 0, 0);
                checkOutput("rst_addr_a", int'(ram_addr_a), 0, 0);
                checkOutput("rst_addr_b", int'(ram_addr_b), 0, 0);
                checkOutput("rst_din_a", int'(ram_din_a), 0, 0);
                checkOutput("rst_din_b", int'(ram_din_b), 0, 0);
                aborted = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (aborted) begin
            @(posedge clk); #1;
            return;
        end
        checkOutput("busy_cycles", cyc, 1792, 0);
        checkOutput("we_a_cycles", wa, 448, 0);
        checkOutput("we_b_cycles", wb, 448, 0);
        checkOutput("we_total", wa + wb, 896, 0);
        checkOutput("idle_addr_a", int'(ram_addr_a), 0, 0);
        checkOutput("idle_din_b", int'(ram_din_b), 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_restart", int'(busy), 0, 0);
    endtask

    task automatic drain_results();
        bin_t e;
        logic signed [DW-1:0] fr, fi;
        checkOutput("sb_depth", sb.size(), N, 0);
        for (int k = 0; k < N && sb.size() > 0; k++) begin
            e  = sb.pop_front();
            fr = mem[k][RE_LSB +: DW];
            fi = mem[k][IM_LSB +: DW];
            checkOutput($sformatf("bin%0d_re", k), int'(fr), e.re, 8);
            checkOutput($sformatf("bin%0d_im", k), int'(fi), e.im, 8);
        end
        sb.delete();
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ab;
        rst       = 1'b0;
        start     = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", int'(busy), 0, 0);
        checkOutput("reset_we_a", int'(ram_we_a), 0, 0);
        checkOutput("reset_we_b", int'(ram_we_b), 0, 0);
        checkOutput("reset_addr_a", int'(ram_addr_a), 0, 0);
        checkOutput("reset_addr_b", int'(ram_addr_b), 0, 0);
        checkOutput("reset_din_a", int'(ram_din_a), 0, 0);
        checkOutput("reset_din_b", int'(ram_din_b), 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        $display("[TB] DC input");
        applyStimulus(0);
        run_transform(0, 0, ab);
        drain_results();

        $display("[TB] period-4 square wave");
        applyStimulus(1);
        run_transform(0, 0, ab);
        drain_results();

        $display("[TB] half-period square wave, start re-pulsed mid-run");
        applyStimulus(2);
        run_transform(700, 0, ab);
        drain_results();

        $display("[TB] random input, start re-pulsed in final write");
        applyStimulus(3);
        run_transform(1792, 0, ab);
        drain_results();

        $display("[TB] reset at cycle 500 then fresh run");
        applyStimulus(3);
        run_transform(0, 500, ab);
        checkOutput("abort_seen", int'(ab), 1, 0);
        sb.delete();
        applyStimulus(3);
        rst = 1'b1;
        run_transform(0, 0, ab);
        drain_results();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
